m_dmem_responder: RTL
=====================

// Module: m_dmem_responder
// PURPOSE
//  Data-memory responder for the processor's load/store port: accepts single-cycle
//  request pulses, inserts a programmable wait-state delay, then commits the write or
//  returns read data with a one-cycle acknowledge. Replaces the zero-latency data RAM
//  so the multicycle datapath can be exercised against slow memory.
// PARAMETERS
//  ADDR_W   12    word-address width
//  DEPTH    4096  implemented words; addresses >= DEPTH are out of range
//  WAIT     2     wait states between request and commit, 0..15
// PORTS
//  w_clk     in   1       clock, all state changes on posedge
//  w_rst_n   in   1       asynchronous, active-low reset
//  w_req     in   1       request strobe, sampled only in IDLE
//  w_we      in   1       1 = store, 0 = load; sampled with w_req
//  w_addr    in   ADDR_W  word address; sampled with w_req
//  w_be      in   4       byte-lane write enables (bit i -> data[8i+7:8i])
//  w_wdata   in   32      store data; sampled with w_req
//  w_busy    out  1       high in WAIT and RESP
//  w_ack     out  1       one-cycle pulse: transaction complete
//  w_rdata   out  32      load data, valid while w_ack=1 and held until next commit
//  w_err     out  1       pulses with w_ack when the latched address >= DEPTH
// BEHAVIOUR
//  - Reset (w_rst_n=0, any time): state=IDLE, counter=0, w_busy=0, w_ack=0,
//    w_rdata=0, w_err=0. RAM contents are not cleared. A transaction in flight is
//    discarded; no write is performed unless its commit edge has already occurred.
//  - FSM states: IDLE, WAIT, RESP.
//    IDLE: on an edge with w_req=1, latch we/addr/be/wdata. If WAIT=0, go to RESP and
//          commit on the same edge. Otherwise load counter=WAIT and go to WAIT.
//    WAIT: each edge decrements the counter. On the edge where counter==1, commit and
//          go to RESP.
//    RESP: w_ack=1 for exactly this cycle. The next edge always returns to IDLE.
//  - Latency: request sampled at edge E0; commit at edge E0+WAIT; w_ack high during
//    the cycle after that edge. Max throughput: 1 transaction per WAIT+2 cycles.
//  - Commit, store: for each i with w_be[i]=1, RAM[addr][8i+7:8i] <= wdata lane.
//    be=0 is a legal no-op store and still acks. w_rdata is unchanged on stores.
//  - Commit, load: w_rdata <= RAM[addr] (full word; be ignored).
//  - Out-of-range address (addr >= DEPTH): store suppressed; load returns w_rdata=0;
//    w_err=1 in the RESP cycle. w_err is otherwise 0.
//  - w_req in WAIT or RESP is ignored. It is not queued; the initiator retries after
//    w_ack. A w_req held high in IDLE starts a new transaction on the edge after RESP.
//  - Read-after-write to the same address in consecutive transactions returns the
//    newly merged word.
//  - Outputs are registered or decoded from state only: no combinational path from
//    inputs to outputs.
// TESTING
//  1 Reset: hold w_rst_n=0 5 cycles -> w_busy=w_ack=w_err=0, w_rdata=0.
//  2 WAIT=2: store addr 8, be=4'hF, wdata=32'h55 at E0 -> w_busy at E0+1..E0+3,
//    w_ack only in cycle after E0+2. Then load addr 8 -> w_rdata=32'h55, w_ack one cycle.
//  3 Byte lanes: RAM[3]=32'h11223344; store be=4'b0101, wdata=32'hAABBCCDD, then load
//    -> 32'h11BB33DD.
//  4 Busy drop: pulse a second w_req (store addr 9) during WAIT -> ignored; RAM[9]
//    unchanged; exactly one w_ack.
//  5 Out of range (DEPTH=16): load addr 20 -> w_ack=1, w_err=1, w_rdata=0. Store addr 20
//    -> no RAM change, w_err=1.
//  6 Abort: w_rst_n low 1 cycle after a store request with WAIT=3 -> no w_ack, RAM
//    unchanged, state IDLE. WAIT=0 variant: ack in the cycle right after the request edge.

Source files
------------

// File: rtl/m_dmem_responder.sv
// m_dmem_responder
//   Data-memory responder for the processor load/store port. A single-cycle
//   request is latched in IDLE, held for a programmable number of wait states,
//   and then committed: stores merge byte lanes into the RAM, and loads return
//   the full word. Completion is signalled by a one-cycle w_ack.
//
// Parameters
//   ADDR_W  word-address width
//   DEPTH   number of implemented words; addresses >= DEPTH are out of range
//   WAIT    wait states between request and commit (0..15)
//
// Ports
//   w_clk     in   clock, all state changes on posedge
//   w_rst_n   in   asynchronous active-low reset
//   w_req     in   request strobe, sampled only in IDLE
//   w_we      in   1 = store, 0 = load
//   w_addr    in   word address
//   w_be      in   byte-lane write enables (bit i -> data[8i+7:8i])
//   w_wdata   in   store data
//   w_busy    out  high in WAIT and RESP
//   w_ack     out  one-cycle completion pulse
//   w_rdata   out  load data, held until the next load commit
//   w_err     out  pulses with w_ack for an out-of-range address

module m_dmem_responder #(
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096,
   parameter int WAIT   = 2
) (
   input  logic              w_clk,
   input  logic              w_rst_n,
   input  logic              w_req,
   input  logic              w_we,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [3:0]        w_be,
   input  logic [31:0]       w_wdata,
   output logic              w_busy,
   output logic              w_ack,
   output logic [31:0]       w_rdata,
   output logic              w_err
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      WAIT_C  = 4'(WAIT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [31:0]       mem [DEPTH];

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;

   logic              cur_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [3:0]        cur_be;
   logic [31:0]       cur_wdata;
   logic              oor;
   logic [IDX_W-1:0]  idx;
   logic              commit;

   // With zero wait states the commit happens on the same edge that samples
   // the request, so the transaction fields come straight from the inputs in
   // IDLE and from the latched copies in WAIT.
   always_comb begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_be    = be_q;
      cur_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         cur_we    = w_we;
         cur_addr  = w_addr;
         cur_be    = w_be;
         cur_wdata = w_wdata;
      end
      oor = ({1'b0, cur_addr} >= DEPTH_W);
      idx = cur_addr[IDX_W-1:0];
   end

   // Next-state logic. The commit strobe is gated by reset so that an edge
   // arriving while reset is held can never write the RAM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_req) begin
               we_d    = w_we;
               addr_d  = w_addr;
               be_d    = w_be;
               wdata_d = w_wdata;
               if (WAIT_C == 4'd0) begin
                  commit  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = WAIT_C;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      commit = commit & w_rst_n;

      ack_d   = commit;
      err_d   = commit & oor;
      rdata_d = rdata_q;
      if (commit && !cur_we) begin
         rdata_d = oor ? 32'h0 : mem[idx];
      end
   end

   // Control and response registers; RAM contents are deliberately not reset.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'd0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   // Byte-lane merge on store commit; out-of-range stores are dropped.
   always_ff @(posedge w_clk) begin
      if (commit && cur_we && !oor) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) begin
               mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
         end
      end
   end

   assign w_busy  = (state_q == S_WAIT) || (state_q == S_RESP);
   assign w_ack   = ack_q;
   assign w_rdata = rdata_q;
   assign w_err   = err_q;

endmodule
